// File: rtl/prince_pkg.sv
// Shared PRINCE linear-layer definitions: mode encodings, M' masks, ShiftRows helpers.
package prince_pkg;

  localparam int unsigned STATE_W = 64;
  localparam int unsigned MODE_W  = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_MPRIME = 2'd0,
    MODE_FWD    = 2'd1,
    MODE_INV    = 2'd2,
    MODE_BYP    = 2'd3
  } mode_e;

  typedef struct packed {
    logic [MODE_W-1:0]  mode;
    logic [STATE_W-1:0] data;
  } beat_t;

  // M0 row masks, listed k = 15 down to 0
  localparam logic [15:0][15:0] M0_MASK = {
    16'h0888, 16'h4044, 16'h2202, 16'h1110,
    16'h8880, 16'h0444, 16'h2022, 16'h1101,
    16'h8808, 16'h4440, 16'h0222, 16'h1011,
    16'h8088, 16'h4404, 16'h2220, 16'h0111
  };

  // M1 is M0 with rows rotated by four; 4-bit wrap gives the mod 16
  function automatic logic [15:0] m1_mask(input logic [3:0] k);
    return M0_MASK[4'(k - 4'd4)];
  endfunction

  function automatic logic [3:0] sr_src(input logic [3:0] i);
    return 4'(i * 4'd5);
  endfunction

  function automatic logic [3:0] sr_inv_src(input logic [3:0] i);
    return 4'(i * 4'd13);
  endfunction

  // Nibble 0 is the top nibble, so nibble i sits at packed index ~i
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s,
                                                    input logic             inv);
    logic [15:0][3:0] sn;
    logic [15:0][3:0] rn;
    logic [3:0]       idx;
    logic [3:0]       src;
    sn = s;
    rn = '0;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      src = inv ? sr_inv_src(idx) : sr_src(idx);
      rn[~idx] = sn[~src];
    end
    return rn;
  endfunction

  function automatic logic [STATE_W-1:0] pre_perm(input logic [STATE_W-1:0] s,
                                                  input logic [MODE_W-1:0]  mode);
    return (mode == MODE_INV) ? shift_rows(s, 1'b1) : s;
  endfunction

  function automatic logic [STATE_W-1:0] post_perm(input logic [STATE_W-1:0] s,
                                                   input logic [MODE_W-1:0]  mode);
    return (mode == MODE_FWD) ? shift_rows(s, 1'b0) : s;
  endfunction

endpackage

// File: rtl/prince_mprime.sv
// Combinational PRINCE M' layer: four 16x16 GF(2) blocks, M0 on outer chunks, M1 on inner.
module prince_mprime
  import prince_pkg::*;
(
  input  logic [STATE_W-1:0] din,
  output logic [STATE_W-1:0] dout
);

  logic [3:0][15:0] a_ch;
  logic [3:0][15:0] y_ch;
  logic [15:0]      mask;

  assign a_ch = din;
  assign dout = y_ch;

  always_comb begin
    y_ch = '0;
    mask = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 16; k++) begin
        mask = (c == 1 || c == 2) ? m1_mask(4'(k)) : M0_MASK[4'(k)];
        y_ch[2'(c)][4'(k)] = ^(a_ch[2'(c)] & mask);
      end
    end
  end

endmodule

// File: rtl/prince_mlayer_pipe.sv
// Pipelined, mode-selectable PRINCE linear layer (M', M, M^-1, bypass) with
// valid/ready back-pressure and an in-flight occupancy count.
module prince_mlayer_pipe
  import prince_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned W_CNT       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic [MODE_W-1:0]  in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic [MODE_W-1:0]  out_mode,
  output logic [W_CNT-1:0]   occupancy
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_depth
    $fatal(1, "prince_mlayer_pipe: PIPE_STAGES must be 1..4");
  end
  if ((64'd1 << W_CNT) <= 64'(PIPE_STAGES)) begin : g_bad_cnt
    $fatal(1, "prince_mlayer_pipe: W_CNT too narrow for PIPE_STAGES");
  end

  localparam int unsigned P = PIPE_STAGES;

  logic [P-1:0]       vld;
  logic [P-1:0]       adv;
  beat_t              stg [P];
  logic [STATE_W-1:0] pre_d;
  logic [STATE_W-1:0] mp_d;
  logic [STATE_W-1:0] mix_d;
  logic               acc;
  logic               emit;

  // Front end: optional SR^-1, then M' unless bypassing
  assign pre_d = pre_perm(in_data, in_mode);

  prince_mprime u_mprime (
    .din  (pre_d),
    .dout (mp_d)
  );

  assign mix_d = (in_mode == MODE_BYP) ? pre_d : mp_d;

  assign in_ready = ~rst & (~vld[0] | adv[0]);
  assign acc      = in_valid & in_ready;
  assign emit     = vld[P-1] & out_ready;

  for (genvar i = 0; i < P; i++) begin : g_stage
    logic  src_v;
    beat_t src_b;
    logic  v_q;
    beat_t b_q;

    if (i == 0) begin : g_head
      assign src_v = acc;
      assign src_b = '{mode: in_mode,
                       data: (P == 1) ? post_perm(mix_d, in_mode) : mix_d};
    end else if (i == 1) begin : g_post
      assign src_v = adv[0];
      assign src_b = '{mode: stg[0].mode, data: post_perm(stg[0].data, stg[0].mode)};
    end else begin : g_delay
      assign src_v = adv[i-1];
      assign src_b = stg[i-1];
    end

    // A stage moves on if anything downstream has a bubble or the tail drains
    if (i == P-1) begin : g_tail
      assign adv[i] = v_q & out_ready;
    end else begin : g_mid
      assign adv[i] = v_q & (out_ready | ~(&vld[P-1:i+1]));
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        b_q <= '0;
      end else if (~v_q | adv[i]) begin
        v_q <= src_v;
        if (src_v) begin
          b_q <= src_b;
        end
      end
    end

    assign vld[i] = v_q;
    assign stg[i] = b_q;
  end

  assign out_valid = vld[P-1];
  assign out_data  = stg[P-1].data;
  assign out_mode  = stg[P-1].mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case ({acc, emit})
        2'b10:   occupancy <= occupancy + W_CNT'(1);
        2'b01:   occupancy <= occupancy - W_CNT'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
